// File: rtl/chacha_param_pkg.sv
// Shared types and constants for the ChaCha20 key/nonce/counter server.
// Type codes, address map, per-type index limits and FSM states.
package chacha_param_pkg;

  localparam logic [1:0] TYPE_KEY     = 2'b00;
  localparam logic [1:0] TYPE_NONCE   = 2'b01;
  localparam logic [1:0] TYPE_COUNTER = 2'b10;
  localparam logic [1:0] TYPE_INVALID = 2'b11;

  localparam logic [3:0] ADDR_KEY0   = 4'd0;
  localparam logic [3:0] ADDR_NONCE0 = 4'd8;
  localparam logic [3:0] ADDR_CTR    = 4'd11;

  localparam int NUM_WORDS = 12;

  localparam logic [4:0] MAX_KEY_IDX   = 5'd7;
  localparam logic [4:0] MAX_NONCE_IDX = 5'd2;
  localparam logic [4:0] MAX_CTR_IDX   = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/chacha_param_server_regfile.sv
// 12x32 parameter storage with host write decode and (type,index) read.
// Counter increment port exists only when COUNTER_AUTOINC_EN is defined.
module chacha_param_regfile
  import chacha_param_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
`ifdef COUNTER_AUTOINC_EN
  input  logic        ctr_inc,
`endif
  input  logic [1:0]  rd_type,
  input  logic [4:0]  rd_index,
  output logic [31:0] rd_data,
  output logic        rd_err,
  output logic        wr_bad
);

  logic [31:0] mem_q [NUM_WORDS];
  logic [31:0] mem_d [NUM_WORDS];
  logic        wr_ok;

  assign wr_ok  = wr_en && (wr_addr <= ADDR_CTR);
  assign wr_bad = wr_en && (wr_addr > ADDR_CTR);

  always_comb begin
    mem_d = mem_q;
`ifdef COUNTER_AUTOINC_EN
    if (ctr_inc) begin
      mem_d[ADDR_CTR] = mem_q[ADDR_CTR] + 32'd1;
    end
`endif
    // host write applied last so it wins over the increment
    if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    unique case (1'b1)
      (rd_type == TYPE_KEY): begin
        if (rd_index <= MAX_KEY_IDX) begin
          rd_data = mem_q[ADDR_KEY0 + {1'b0, rd_index[2:0]}];
        end else begin
          rd_err = 1'b1;
        end
      end
      (rd_type == TYPE_NONCE): begin
        if (rd_index <= MAX_NONCE_IDX) begin
          rd_data = mem_q[ADDR_NONCE0 + {2'b00, rd_index[1:0]}];
        end else begin
          rd_err = 1'b1;
        end
      end
      (rd_type == TYPE_COUNTER): begin
        if (rd_index <= MAX_CTR_IDX) begin
          rd_data = mem_q[ADDR_CTR];
        end else begin
          rd_err = 1'b1;
        end
      end
      default: rd_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/chacha_param_server.sv
// Chunk responder for the ChaCha20 top: one beat per captured request.
// Optional COUNTER_AUTOINC_EN bumps the counter after each counter beat.
module chacha_param_server
  import chacha_param_pkg::*;
#(
  parameter int RESP_LATENCY = 1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        chunk_request,
  input  logic [1:0]  request_type,
  input  logic [4:0]  chunk_index,
  output logic        chunk_valid,
  output logic [1:0]  chunk_type,
  output logic [31:0] chunk,
  output logic        pending,
  output logic        err
);

  localparam logic [3:0] LAT_M1 = 4'(RESP_LATENCY - 1);
  localparam bit DIRECT = (RESP_LATENCY == 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        wr_bad;

`ifdef COUNTER_AUTOINC_EN
  logic hit_q, hit_d;
  logic ctr_inc;
  assign ctr_inc = (state_q == ST_RESP) && hit_q;
`endif

  chacha_param_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
`ifdef COUNTER_AUTOINC_EN
    .ctr_inc  (ctr_inc),
`endif
    .rd_type  (request_type),
    .rd_index (chunk_index),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .wr_bad   (wr_bad)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    data_d  = data_q;
    err_d   = err_q | wr_bad;
`ifdef COUNTER_AUTOINC_EN
    hit_d   = hit_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (chunk_request) begin
          if (request_type == TYPE_INVALID) begin
            err_d = 1'b1;
          end else begin
            type_d  = request_type;
            data_d  = rd_data;
            err_d   = err_d | rd_err;
`ifdef COUNTER_AUTOINC_EN
            hit_d   = (request_type == TYPE_COUNTER) && !rd_err;
`endif
            cnt_d   = LAT_M1;
            state_d = DIRECT ? ST_RESP : ST_WAIT;
          end
        end
      end
      // counter reaching 1 here means the next cycle is the beat
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      type_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef COUNTER_AUTOINC_EN
      hit_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef COUNTER_AUTOINC_EN
      hit_q   <= hit_d;
`endif
    end
  end

  assign chunk_valid = (state_q == ST_RESP);
  assign pending     = (state_q == ST_WAIT);
  assign chunk_type  = type_q;
  assign chunk       = data_q;
  assign err         = err_q;

endmodule

// File: tb/tb_chacha_param_server.sv
// Bench for chacha_param_server: directed cases plus random traffic
// checked against an array model; second instance at RESP_LATENCY=4.
module tb_chacha_param_server;

  logic        clk = 1'b0;
  logic        rst, wr_en, chunk_request;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  request_type;
  logic [4:0]  chunk_index;
  logic        chunk_valid, pending, err;
  logic [1:0]  chunk_type;
  logic [31:0] chunk;

  logic        rst4, wr_en4, req4;
  logic [3:0]  wr_addr4;
  logic [31:0] wr_data4;
  logic [1:0]  rtype4;
  logic [4:0]  idx4;
  logic        valid4, pending4, err4;
  logic [1:0]  ctype4;
  logic [31:0] chunk4;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] mem_m [12];
  bit err_m = 1'b0;

  always #5 clk = ~clk;

  chacha_param_server #(.RESP_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .chunk_request(chunk_request),
    .request_type(request_type), .chunk_index(chunk_index),
    .chunk_valid(chunk_valid), .chunk_type(chunk_type),
    .chunk(chunk), .pending(pending), .err(err)
  );

  chacha_param_server #(.RESP_LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst4), .wr_en(wr_en4), .wr_addr(wr_addr4),
    .wr_data(wr_data4), .chunk_request(req4),
    .request_type(rtype4), .chunk_index(idx4),
    .chunk_valid(valid4), .chunk_type(ctype4),
    .chunk(chunk4), .pending(pending4), .err(err4)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit model_bad(input int t, input int idx);
    return !((t == 0 && idx <= 7) || (t == 1 && idx <= 2) ||
             (t == 2 && idx == 0));
  endfunction

  function automatic logic [31:0] model_read(input int t, input int idx);
    if (model_bad(t, idx)) return 32'h0;
    if (t == 0) return mem_m[idx];
    if (t == 1) return mem_m[8 + idx];
    return mem_m[11];
  endfunction

  function automatic void model_write(input int wa, input logic [31:0] wd);
    if (wa < 12) mem_m[wa] = wd;
    else err_m = 1'b1;
  endfunction

  task automatic wr(input int wa, input logic [31:0] wd);
    wr_en = 1'b1;
    wr_addr = wa[3:0];
    wr_data = wd;
    step();
    wr_en = 1'b0;
    model_write(wa, wd);
  endtask

  int last_beat = 0;

  // requester: holds request until served, one stale cycle, one low cycle
  task automatic serve(input int t, input int idx, input bit do_wr,
                       input int wa, input logic [31:0] wd,
                       output logic [31:0] got);
    logic [31:0] exp;
    int lat;
    bit seen;
    exp = model_read(t, idx);
    if (model_bad(t, idx)) err_m = 1'b1;
    chunk_request = 1'b1;
    request_type = t[1:0];
    chunk_index = idx[4:0];
    if (do_wr) begin
      wr_en = 1'b1;
      wr_addr = wa[3:0];
      wr_data = wd;
      model_write(wa, wd);
    end
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      step();
      wr_en = 1'b0;
      lat++;
      if (chunk_valid) seen = 1'b1;
    end
    got = chunk;
    last_beat = cyc;
    check("latency", lat, 1);
    check("data", chunk, exp);
    check("type", {30'd0, chunk_type}, t);
`ifdef COUNTER_AUTOINC_EN
    if (t == 2 && !model_bad(t, idx)) mem_m[11] = mem_m[11] + 32'd1;
`endif
    step();
    check("no_second_beat", {31'd0, chunk_valid}, 0);
    check("err", {31'd0, err}, {31'd0, err_m});
    step();
    check("idle_no_beat", {31'd0, chunk_valid}, 0);
    chunk_request = 1'b0;
    step();
  endtask

  task automatic bad_type();
    chunk_request = 1'b1;
    request_type = 2'b11;
    chunk_index = 5'($urandom_range(0, 7));
    err_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t11_no_beat", {30'd0, chunk_valid, pending}, 0);
    end
    chunk_request = 1'b0;
    step();
    check("t11_err", {31'd0, err}, 1);
  endtask

  logic [31:0] got;
  int prev;
  int t_r, i_r, a_r;
  bit w_r;
  bit seen4;
  int lat4;

  initial begin
    rst = 1'b1; rst4 = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    chunk_request = 0; request_type = 0; chunk_index = 0;
    wr_en4 = 0; wr_addr4 = 0; wr_data4 = 0;
    req4 = 0; rtype4 = 0; idx4 = 0;
    for (int i = 0; i < 12; i++) mem_m[i] = 32'h0;
    step(); step();
    check("rst_valid", {31'd0, chunk_valid}, 0);
    check("rst_chunk", chunk, 0);
    check("rst_type", {30'd0, chunk_type}, 0);
    check("rst_pend_err", {30'd0, pending, err}, 0);
    rst = 1'b0; rst4 = 1'b0;
    step();

    for (int i = 0; i < 8; i++) wr(i, 32'h11111111 * (i + 1));
    serve(0, 5, 0, 0, 0, got);
    check("t1_key5", got, 32'h66666666);

    for (int i = 8; i < 12; i++) wr(i, $urandom);
    for (int k = 0; k < 12; k++) begin
      prev = last_beat;
      if (k < 8) serve(0, k, 0, 0, 0, got);
      else if (k < 11) serve(1, k - 8, 0, 0, 0, got);
      else serve(2, 0, 0, 0, 0, got);
      if (k > 0) check("t2_period", last_beat - prev, 4);
    end
    check("t2_err", {31'd0, err}, 0);

    wr(2, 32'h5);
    serve(0, 2, 1, 2, 32'hAAAA0000, got);
    check("t4_old", got, 32'h5);
    serve(0, 2, 0, 0, 0, got);
    check("t4_new", got, 32'hAAAA0000);

    wr(11, 32'hFFFFFFFF);
    serve(2, 0, 0, 0, 0, got);
    check("t6_ctr1", got, 32'hFFFFFFFF);
    serve(2, 0, 0, 0, 0, got);
`ifdef COUNTER_AUTOINC_EN
    check("t6_ctr2", got, 32'h0);
`else
    check("t6_ctr2", got, 32'hFFFFFFFF);
`endif

    serve(1, 3, 0, 0, 0, got);
    check("t3_zero", got, 0);
    check("t3_err", {31'd0, err}, 1);
    bad_type();
    serve(0, 1, 0, 0, 0, got);
    check("t3_sticky", {31'd0, err}, 1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) wr($urandom_range(0, 15), $urandom);
      t_r = $urandom_range(0, 3);
      i_r = $urandom_range(0, 8);
      w_r = ($urandom_range(0, 1) == 1);
      a_r = $urandom_range(0, 15);
      if (t_r == 3) bad_type();
      else serve(t_r, i_r, w_r, a_r, $urandom, got);
    end

    wr_en4 = 1'b1; wr_addr4 = 4'd0; wr_data4 = 32'hC0FFEE00;
    step();
    wr_en4 = 1'b0;
    req4 = 1'b1; rtype4 = 2'b00; idx4 = 5'd0;
    lat4 = 0; seen4 = 1'b0;
    while (!seen4 && lat4 < 20) begin
      step();
      lat4++;
      if (valid4) seen4 = 1'b1;
      else check("t5_pending", {31'd0, pending4}, 1);
    end
    check("t5_latency", lat4, 4);
    check("t5_data", chunk4, 32'hC0FFEE00);
    step();
    req4 = 1'b0;
    step(); step();
    req4 = 1'b1;
    step(); step();
    check("t5_in_wait", {31'd0, pending4}, 1);
    req4 = 1'b0;
    rst4 = 1'b1;
    #2;
    rst4 = 1'b0;
    seen4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (valid4) seen4 = 1'b1;
    end
    check("t5_no_beat", {31'd0, seen4}, 0);
    check("t5_outs", {chunk4[29:0], ctype4} | {29'd0, valid4, pending4, err4}, 0);
    check("t5_chunk", chunk4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
